// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding, stall/flush, multiply sequencing, E-stage flags.
// Optional PIPE_PERF_EN adds saturating StallCnt/FlushCnt counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned PERF_W  = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       MulStartE,
  input  logic [3:0] FlagsNextE,
  output logic [3:0] FlagsE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MulBusy,
  output logic       MulDoneE
`ifdef PIPE_PERF_EN
  ,
  output logic [PERF_W-1:0] StallCnt,
  output logic [PERF_W-1:0] FlushCnt
`endif
);

  if (MUL_LAT < 2 || MUL_LAT > 15) begin : gBadLat
    $error("MUL_LAT must be in 2..15");
  end
  if (PERF_W < 1) begin : gBadW
    $error("PERF_W must be at least 1");
  end

  typedef enum logic {RUN, MUL} state_t;

  state_t     state;
  logic [3:0] cnt;

  logic ldStall;
  logic pcWr;
  logic inMul;
  logic startMul;
  logic runMode;
  logic lastMul;

  assign ldStall  = MemtoRegE &&
                    (WA3E == RA1D || WA3E == RA2D);
  assign pcWr     = PCSrcD | PCSrcE | PCSrcM;
  assign inMul    = (state == MUL);
  assign startMul = !inMul && MulStartE;
  assign runMode  = !inMul && !MulStartE;
  assign lastMul  = inMul && (cnt == 4'd1);

  function automatic logic [1:0] fwdSel(
    input logic [3:0] ra
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != 4'hF) begin
      if (RegWriteM && WA3M == ra)
        sel = 2'b10;
      else if (RegWriteW && WA3W == ra)
        sel = 2'b01;
    end
    return sel;
  endfunction

  // Forwarding selects and pipeline stall/flush decode
  always_comb begin
    ForwardAE = fwdSel(RA1E);
    ForwardBE = fwdSel(RA2E);
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    MulBusy   = inMul;
    MulDoneE  = 1'b0;
    unique case (1'b1)
      inMul: begin
        StallF   = 1'b1;
        StallD   = 1'b1;
        MulDoneE = lastMul;
        StallE   = !lastMul;
        FlushM   = !lastMul;
      end
      startMul: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end
      runMode: begin
        StallF = ldStall | pcWr;
        StallD = ldStall;
        FlushD = pcWr | PCSrcW | BranchTakenE;
        FlushE = ldStall | BranchTakenE;
      end
      default: ;
    endcase
  end

  // Multiply sequencer: RUN -> MUL for MUL_LAT-1 further cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (MulStartE) begin
            state <= MUL;
            cnt   <= 4'(MUL_LAT - 1);
          end
        end
        MUL: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= RUN;
        end
        default: begin
          state <= RUN;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Flags advance only when the E register takes a new instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      FlagsE <= 4'h0;
    else if (!StallE && !FlushE)
      FlagsE <= FlagsNextE;
  end

`ifdef PIPE_PERF_EN
  localparam logic [PERF_W-1:0] ONE =
    {{(PERF_W-1){1'b0}}, 1'b1};

  // Saturating stall and branch-flush event counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallD && StallCnt != '1)
        StallCnt <= StallCnt + ONE;
      if (BranchTakenE && FlushCnt != '1)
        FlushCnt <= FlushCnt + ONE;
    end
  end
`endif

endmodule
